// File: rtl/rggen_apb_bit_field_access_bridge.sv
// rggen_apb_bit_field_access_bridge: APB4 slave that turns each transfer into exactly one register access strobe
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_psel .. i_pwdata         APB4 request
//   o_pready/o_prdata/o_pslverr APB4 response, two wait states
//   o_valid                    one-hot per-register strobe, high for exactly one cycle
//   o_read_mask/o_write_mask/o_write_data  shared access qualifiers, valid with o_valid
//   i_read_data                concatenated register values, register i at [i*BUS_WIDTH +: BUS_WIDTH]
module rggen_apb_bit_field_access_bridge #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int BUS_WIDTH     = 32,
   parameter int REGISTERS     = 4,
   parameter int BASE_ADDRESS  = 0,
   parameter int ERROR_STATUS  = 1
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_psel,
   input  logic                           i_penable,
   input  logic [ADDRESS_WIDTH-1:0]       i_paddr,
   input  logic                           i_pwrite,
   input  logic [BUS_WIDTH/8-1:0]         i_pstrb,
   input  logic [BUS_WIDTH-1:0]           i_pwdata,
   output logic                           o_pready,
   output logic [BUS_WIDTH-1:0]           o_prdata,
   output logic                           o_pslverr,
   output logic [REGISTERS-1:0]           o_valid,
   output logic [BUS_WIDTH-1:0]           o_read_mask,
   output logic [BUS_WIDTH-1:0]           o_write_mask,
   output logic [BUS_WIDTH-1:0]           o_write_data,
   input  logic [REGISTERS*BUS_WIDTH-1:0] i_read_data
);
   localparam int BYTES = BUS_WIDTH / 8;
   localparam int SHIFT = $clog2(BYTES);
   localparam int IW    = (REGISTERS > 1) ? $clog2(REGISTERS) : 1;
   localparam logic [ADDRESS_WIDTH-1:0] BASE = ADDRESS_WIDTH'(BASE_ADDRESS);
   typedef enum logic [1:0] {IDLE, ACCESS, RESPONSE} state_t;
   state_t                   state;
   logic [ADDRESS_WIDTH:0]   diff;
   logic [ADDRESS_WIDTH-1:0] word;
   logic                     hit_c;
   logic [IW-1:0]            index_c;
   logic [BUS_WIDTH-1:0]     wmask_c;
   logic                     hit;
   logic                     is_write;
   logic [IW-1:0]            index;
   // The extra top bit of diff is the borrow: set when the address lies below the base.
   always_comb begin
      diff    = {1'b0, i_paddr} - {1'b0, BASE};
      word    = diff[ADDRESS_WIDTH-1:0] >> SHIFT;
      hit_c   = !diff[ADDRESS_WIDTH] && (word < ADDRESS_WIDTH'(REGISTERS));
      index_c = IW'(word);
      wmask_c = '0;
      for (int b = 0; b < BYTES; b++) wmask_c[8*b +: 8] = {8{i_pstrb[b]}};
   end
   // Transfers are accepted only in IDLE, so a response held by the master can never relaunch a strobe.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         hit          <= 1'b0;
         is_write     <= 1'b0;
         index        <= '0;
         o_pready     <= 1'b0;
         o_prdata     <= '0;
         o_pslverr    <= 1'b0;
         o_valid      <= '0;
         o_read_mask  <= '0;
         o_write_mask <= '0;
         o_write_data <= '0;
      end else begin
         case (state)
            IDLE: if (i_psel && i_penable) begin
               state        <= ACCESS;
               hit          <= hit_c;
               is_write     <= i_pwrite;
               index        <= index_c;
               o_valid      <= hit_c ? REGISTERS'(1) << index_c : '0;
               o_read_mask  <= i_pwrite ? '0 : '1;
               o_write_mask <= i_pwrite ? wmask_c : '0;
               o_write_data <= i_pwrite ? i_pwdata : '0;
            end
            ACCESS: begin
               state        <= RESPONSE;
               o_valid      <= '0;
               o_read_mask  <= '0;
               o_write_mask <= '0;
               o_write_data <= '0;
               o_pready     <= 1'b1;
               o_prdata     <= (hit && !is_write) ? i_read_data[index*BUS_WIDTH +: BUS_WIDTH] : '0;
               o_pslverr    <= !hit && (ERROR_STATUS != 0);
            end
            default: begin
               state     <= IDLE;
               o_pready  <= 1'b0;
               o_prdata  <= '0;
               o_pslverr <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rggen_apb_bit_field_access_bridge.sv
// tb_rggen_apb_bit_field_access_bridge: randomized APB transfers checked against a transaction-level register model
module tb_rggen_apb_bit_field_access_bridge;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         psel = 1'b0;
   logic         penable = 1'b0;
   logic [7:0]   paddr = '0;
   logic         pwrite = 1'b0;
   logic [3:0]   pstrb = '0;
   logic [31:0]  pwdata = '0;
   logic         pready, pslverr, ok_pready, ok_pslverr;
   logic [31:0]  prdata, ok_prdata;
   logic [3:0]   valid, ok_valid;
   logic [31:0]  rmask, wmask, wdata, ok_rmask, ok_wmask, ok_wdata;
   logic [127:0] read_data;
   logic [31:0]  bank [4];
   logic [31:0]  ref_regs [4];
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;

   rggen_apb_bit_field_access_bridge #(.ERROR_STATUS(1)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_psel(psel), .i_penable(penable), .i_paddr(paddr),
      .i_pwrite(pwrite), .i_pstrb(pstrb), .i_pwdata(pwdata), .o_pready(pready), .o_prdata(prdata),
      .o_pslverr(pslverr), .o_valid(valid), .o_read_mask(rmask), .o_write_mask(wmask),
      .o_write_data(wdata), .i_read_data(read_data));

   rggen_apb_bit_field_access_bridge #(.ERROR_STATUS(0)) dut_ok (
      .i_clk(clk), .i_rst_n(rst_n), .i_psel(psel), .i_penable(penable), .i_paddr(paddr),
      .i_pwrite(pwrite), .i_pstrb(pstrb), .i_pwdata(pwdata), .o_pready(ok_pready), .o_prdata(ok_prdata),
      .o_pslverr(ok_pslverr), .o_valid(ok_valid), .o_read_mask(ok_rmask), .o_write_mask(ok_wmask),
      .o_write_data(ok_wdata), .i_read_data(read_data));

   // Register bank reacting to the main DUT's strobes: register 0 is read-to-clear, all are byte-writable.
   assign read_data = {bank[3], bank[2], bank[1], bank[0]};
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank[0] <= 32'h0000_000F;
         bank[1] <= 32'h0000_00A5;
         bank[2] <= 32'h0;
         bank[3] <= 32'h0;
      end else begin
         for (int i = 0; i < 4; i++)
            if (valid[i]) bank[i] <= (i == 0 && rmask != 0) ? 32'h0 : (bank[i] & ~wmask) | (wdata & wmask);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic reset_ref();
      ref_regs[0] = 32'h0000_000F;
      ref_regs[1] = 32'h0000_00A5;
      ref_regs[2] = 32'h0;
      ref_regs[3] = 32'h0;
   endtask

   // Starts the setup phase immediately; returns one cycle after the response with the bus released.
   task automatic xfer(input logic [7:0] addr, input logic w, input logic [3:0] strb, input logic [31:0] data);
      int          idx = int'(addr) / 4;
      bit          hit = addr < 8'd16;
      logic [31:0] m = '0;
      logic [31:0] exp_rd = '0;
      int          strobes = 0;
      int          cyc = 0;
      bit          done = 0;
      for (int b = 0; b < 4; b++) if (strb[b]) m[8*b +: 8] = 8'hFF;
      if (hit && !w) begin
         exp_rd = ref_regs[idx];
         if (idx == 0) ref_regs[0] = 32'h0;
      end
      if (hit && w) ref_regs[idx] = (ref_regs[idx] & ~m) | (data & m);
      psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = w; pstrb = strb; pwdata = data;
      @(posedge clk); #1 penable = 1'b1;
      for (int c = 0; c < 8 && !done; c++) begin
         @(negedge clk);
         cyc++;
         if (valid != 0) begin
            strobes++;
            check("valid", valid, hit ? 4'b1 << idx : 4'b0);
            check("read_mask", rmask, w ? 32'h0 : 32'hFFFF_FFFF);
            check("write_mask", wmask, w ? m : 32'h0);
            check("write_data", wdata, w ? data : 32'h0);
         end
         if (pready) begin
            done = 1;
            check("latency", cyc, 3);
            check("prdata", prdata, exp_rd);
            check("pslverr", pslverr, !hit);
            check("ok_pready", ok_pready, 1);
            check("ok_pslverr", ok_pslverr, 0);
         end
      end
      if (!done) check("pready_timeout", 0, 1);
      check("strobe_count", strobes, hit ? 1 : 0);
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
   endtask

   task automatic idle_check();
      @(negedge clk);
      check("idle_pready", pready, 0);
      check("idle_valid", valid, 0);
   endtask

   initial begin
      reset_ref();
      repeat (2) @(posedge clk);
      #1;
      check("rst_pready", pready, 0);
      check("rst_pslverr", pslverr, 0);
      check("rst_prdata", prdata, 0);
      check("rst_valid", valid, 0);
      check("rst_masks", {rmask, wmask}, 0);
      check("rst_wdata", wdata, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      xfer(8'h04, 1'b0, 4'h0, 32'h0);
      idle_check();
      xfer(8'h08, 1'b1, 4'b0101, 32'h1122_3344);
      xfer(8'h08, 1'b0, 4'hF, 32'h0);
      xfer(8'h10, 1'b0, 4'h0, 32'h0);
      xfer(8'h00, 1'b0, 4'h0, 32'h0);
      xfer(8'h00, 1'b0, 4'h0, 32'h0);
      idle_check();
      // Reset pulse while a write strobe is on the bus.
      psel = 1'b1; penable = 1'b0; paddr = 8'h0C; pwrite = 1'b1; pstrb = 4'hF; pwdata = 32'hDEAD_BEEF;
      @(posedge clk); #1 penable = 1'b1;
      @(posedge clk); #1;
      check("pre_rst_valid", valid, 4'b1000);
      @(negedge clk) rst_n = 1'b0;
      #1;
      check("midrst_valid", valid, 0);
      check("midrst_masks", {rmask, wmask}, 0);
      check("midrst_wdata", wdata, 0);
      check("midrst_pready", pready, 0);
      psel = 1'b0; penable = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      reset_ref();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("postrst_pready", pready, 0);
         check("postrst_valid", valid, 0);
      end
      xfer(8'h00, 1'b0, 4'h0, 32'h0);
      xfer(8'h0C, 1'b0, 4'h0, 32'h0);
      xfer(8'h05, 1'b0, 4'h0, 32'h0);
      xfer(8'h06, 1'b1, 4'h0, 32'hFFFF_FFFF);
      xfer(8'h04, 1'b0, 4'h0, 32'h0);
      for (int n = 0; n < 60; n++) begin
         xfer(8'($urandom_range(0, 23)), 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
         if ($urandom_range(0, 1) == 1) idle_check();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rggen_apb_bit_field_access_bridge.md
Name: rggen_apb_bit_field_access_bridge

Overview:
- APB4 slave front end that turns each bus transfer into exactly one single-cycle register access strobe: valid, read mask, write mask and write data.
- The strobe goes to a bank of REGISTERS word-wide registers built from bit-field cells, including read-to-clear and write-0/1-to-set types.
- Because those cells have side effects, the block guarantees one and only one strobe per bus transfer.
- It also collects the register read data and returns the APB response.

Parameters:
- ADDRESS_WIDTH, 8, APB address width in bits.
- BUS_WIDTH, 32, data width in bits (multiple of 8).
- REGISTERS, 4, number of registers, one per word.
- BASE_ADDRESS, 0, byte address of register 0; register i sits at BASE_ADDRESS + i*(BUS_WIDTH/8).
- ERROR_STATUS, 1, 1 means unmapped accesses return PSLVERR=1; 0 means OKAY with zero data.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_psel  input  1  APB select
- i_penable  input  1  APB enable (access phase)
- i_paddr  input  ADDRESS_WIDTH  byte address
- i_pwrite  input  1  1 means write
- i_pstrb  input  BUS_WIDTH/8  write byte strobes
- i_pwdata  input  BUS_WIDTH  write data
- o_pready  output  1  transfer complete
- o_prdata  output  BUS_WIDTH  read data
- o_pslverr  output  1  error response
- o_valid  output  REGISTERS  one-hot access strobe per register
- o_read_mask  output  BUS_WIDTH  read mask, shared by all registers
- o_write_mask  output  BUS_WIDTH  write mask, shared
- o_write_data  output  BUS_WIDTH  write data, shared
- i_read_data  input  REGISTERS*BUS_WIDTH  concatenated register values; register i occupies bits [i*BUS_WIDTH +: BUS_WIDTH]

Behaviour:
- Reset: i_rst_n is the asynchronous, active-low reset and i_clk the clock. While reset is asserted:
  - FSM is in IDLE.
  - o_pready, o_pslverr, o_valid, o_read_mask, o_write_mask and o_write_data are 0.
  - o_prdata is 0.
- FSM IDLE:
  - Transition: i_psel & i_penable sampled high -> latch address, direction, strobes and data; go to ACCESS. Otherwise stay.
  - Decode: word index = (i_paddr - BASE_ADDRESS) >> log2(BUS_WIDTH/8). The low byte-offset bits are ignored. Hit when i_paddr >= BASE_ADDRESS and index < REGISTERS.
- FSM ACCESS (exactly one cycle):
  - Hit: o_valid[index]=1; all other bits of o_valid stay 0.
  - Read: o_read_mask = all ones, o_write_mask = 0.
  - Write: o_read_mask = 0, o_write_mask = each i_pstrb bit expanded to 8 bits, o_write_data = latched i_pwdata.
  - Read data: on a read hit, register i_read_data slice [index] at the end of this cycle; this is the pre-update value.
  - Miss: no o_valid; captured read data = 0; error flag = ERROR_STATUS.
  - Transition: always go to RESPONSE.
- FSM RESPONSE (exactly one cycle):
  - o_pready=1.
  - o_prdata = captured data on a read, 0 on a write.
  - o_pslverr = error flag.
  - Transition: go to IDLE.
- Outside ACCESS, o_valid, o_read_mask, o_write_mask and o_write_data are all 0. All outputs are registered.
- Latency: the access phase ends with o_pready on the 3rd cycle of i_penable, i.e. two wait states. This latency is fixed for hits, misses, reads and writes.
- No relaunch: a transfer held in RESPONSE cannot start a second strobe. APB guarantees i_penable=0 in the cycle after o_pready, and a new transfer is only accepted in IDLE.
- Boundary cases:
  - Write with i_pstrb=0: the strobe is still issued with both masks 0, so it has no register effect, and the response is OKAY.
  - Read with non-zero i_pstrb: i_pstrb is ignored and the access is treated as a read.
  - Protocol violation (i_psel dropped during ACCESS or RESPONSE): the sequence completes internally. A strobe already issued is not rolled back, and the block returns to IDLE.
  - Reset asserted mid-operation: all outputs go to 0 immediately and the FSM returns to IDLE. A strobe in progress is truncated, and no strobe is issued after reset is released.
  - Back-to-back transfers: the setup phase of the next transfer overlaps the IDLE return; a new access is accepted as soon as i_penable is seen in IDLE.

Test Plan:
- Reset, then read addr 0x04 with i_read_data slice1=0x0000_00A5 -> o_valid=4'b0010 for 1 cycle with o_read_mask=0xFFFF_FFFF; o_pready on the 3rd access-phase cycle with o_prdata=0x0000_00A5, o_pslverr=0.
- Write addr 0x08, i_pstrb=4'b0101, i_pwdata=0x1122_3344 -> single o_valid=4'b0100 with o_write_mask=0x00FF_00FF, o_write_data=0x1122_3344, o_read_mask=0; response o_prdata=0, o_pslverr=0.
- Read addr 0x10 (unmapped, ERROR_STATUS=1) -> o_valid stays 0 throughout; o_pready with o_pslverr=1, o_prdata=0. Repeat with ERROR_STATUS=0 -> o_pslverr=0.
- Read-to-clear check: two consecutive reads of addr 0x00 against a read-to-clear model initialised to 0xF -> exactly 2 strobes total; first read returns 0xF, second returns 0x0.
- Reset pulse during ACCESS of a write -> outputs 0 within the reset cycle; after release there is no o_pready and no o_valid until a new transfer; the next read of addr 0x00 completes normally.
- Misaligned addr 0x05 read -> treated as register 1 (o_valid=4'b0010); write with i_pstrb=0 -> strobe issued with both masks 0, response OKAY.
